// File: rtl/vending_machine.sv
// Purpose : three-product vending controller; one-shot payment vs fixed price, dispense with change or full refund.
// Latency : 2 clock edges from request sample to product pulse / balance valid; one transaction per 3 cycles minimum.
// Backpr. : none; inputs seen while busy are ignored, and a changed input still present on return to IDLE starts a new request.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   select[1:0]       00 chocolate, 01 ice cream, 10 cold drink, 11 invalid
//   money[5:0]        amount tendered, 0 = no payment
//   balance[5:0]      registered change or refund, held until the next evaluation
//   Chocolate, icecream, cold_drink   one-cycle product release pulses
module vending_machine #(
    parameter logic [5:0] PRICE_CHOC = 6'd10,
    parameter logic [5:0] PRICE_ICE  = 6'd20,
    parameter logic [5:0] PRICE_COLD = 6'd50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] select,
    input  logic [5:0] money,
    output logic [5:0] balance,
    output logic       Chocolate,
    output logic       icecream,
    output logic       cold_drink
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        DISPENSE = 2'd2,
        REFUND   = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] prev_in;
    logic [5:0] amt;
    logic [1:0] sel;
    logic [5:0] price;
    logic       request;

    // A request is a nonzero payment whose {select, money} differs from the
    // last value seen in IDLE, so a held input fires only once.
    assign request = (money != 6'd0) && ({select, money} != prev_in);

    always_comb begin
        price = 6'd0;
        case (sel)
            2'b00:   price = PRICE_CHOC;
            2'b01:   price = PRICE_ICE;
            2'b10:   price = PRICE_COLD;
            default: price = 6'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_in    <= 8'd0;
            amt        <= 6'd0;
            sel        <= 2'b00;
            balance    <= 6'd0;
            Chocolate  <= 1'b0;
            icecream   <= 1'b0;
            cold_drink <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // History only tracks the inputs while idle; it stays
                    // frozen while busy so a change made mid-transaction is
                    // picked up once IDLE resumes.
                    prev_in <= {select, money};
                    if (request) begin
                        amt   <= money;
                        sel   <= select;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if ((sel != 2'b11) && (amt >= price)) begin
                        balance    <= amt - price;
                        Chocolate  <= (sel == 2'b00);
                        icecream   <= (sel == 2'b01);
                        cold_drink <= (sel == 2'b10);
                        state      <= DISPENSE;
                    end else begin
                        balance <= amt;
                        state   <= REFUND;
                    end
                end
                DISPENSE, REFUND: begin
                    Chocolate  <= 1'b0;
                    icecream   <= 1'b0;
                    cold_drink <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Purpose : directed self-checking bench for vending_machine.
// Latency : checks product pulse and balance two edges after each request.
// Backpr. : n/a; stimulus is a fixed cycle schedule.
module tb_vending_machine;

    logic       clk;
    logic       reset;
    logic [1:0] select;
    logic [5:0] money;
    logic [5:0] balance;
    logic       Chocolate;
    logic       icecream;
    logic       cold_drink;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] P_NONE = 3'b000;
    localparam logic [2:0] P_CHOC = 3'b100;
    localparam logic [2:0] P_ICE  = 3'b010;
    localparam logic [2:0] P_COLD = 3'b001;

    vending_machine dut (
        .clk        (clk),
        .reset      (reset),
        .select     (select),
        .money      (money),
        .balance    (balance),
        .Chocolate  (Chocolate),
        .icecream   (icecream),
        .cold_drink (cold_drink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] prod();
        return {5'd0, Chocolate, icecream, cold_drink};
    endfunction

    // Present one request and check EVAL, the result cycle and the return to IDLE.
    task automatic txn(input string tag, input logic [1:0] s, input logic [5:0] m,
                       input logic [2:0] exp_prod, input logic [5:0] exp_bal);
        select = s;
        money  = m;
        step();
        chk({tag, "_eval_prod"}, prod(), 8'(P_NONE));
        step();
        chk({tag, "_prod"}, prod(), 8'(exp_prod));
        chk({tag, "_bal"}, 8'(balance), 8'(exp_bal));
        step();
        chk({tag, "_clear"}, prod(), 8'(P_NONE));
        chk({tag, "_bal_hold"}, 8'(balance), 8'(exp_bal));
    endtask

    task automatic idle_quiet(input string tag, input int n, input logic [5:0] exp_bal);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_quiet"}, prod(), 8'(P_NONE));
        end
        chk({tag, "_quiet_bal"}, 8'(balance), 8'(exp_bal));
    endtask

    initial begin
        reset  = 1'b1;
        select = 2'b00;
        money  = 6'd0;
        step();
        step();
        chk("rst_bal", 8'(balance), 8'd0);
        chk("rst_prod", prod(), 8'(P_NONE));
        reset = 1'b0;

        // Exact price chocolate, then no retrigger while held.
        txn("choc_exact", 2'b00, 6'd10, P_CHOC, 6'd0);
        idle_quiet("choc_hold", 2, 6'd0);

        // Ice cream held ten cycles: a single pulse only.
        txn("ice_exact", 2'b01, 6'd20, P_ICE, 6'd0);
        idle_quiet("ice_hold", 7, 6'd0);

        // Money back to 0 then the same value retriggers.
        money = 6'd0;
        step();
        chk("zero_prod", prod(), 8'(P_NONE));
        txn("ice_again", 2'b01, 6'd20, P_ICE, 6'd0);

        // Cold drink exact, then with change.
        txn("cold_exact", 2'b10, 6'd50, P_COLD, 6'd0);
        txn("cold_change", 2'b10, 6'd63, P_COLD, 6'd13);

        // Refunds: insufficient funds and invalid selection.
        txn("cold_short", 2'b10, 6'd10, P_NONE, 6'd10);
        txn("invalid_sel", 2'b11, 6'd30, P_NONE, 6'd30);

        // Select changes during EVAL: first transaction uses latched select,
        // then the changed input is taken as a new request.
        select = 2'b00;
        money  = 6'd20;
        step();
        chk("mid_eval_prod", prod(), 8'(P_NONE));
        select = 2'b01;
        step();
        chk("mid_choc_prod", prod(), 8'(P_CHOC));
        chk("mid_choc_bal", 8'(balance), 8'd10);
        step();
        chk("mid_choc_clear", prod(), 8'(P_NONE));
        step();
        chk("mid_ice_eval", prod(), 8'(P_NONE));
        step();
        chk("mid_ice_prod", prod(), 8'(P_ICE));
        chk("mid_ice_bal", 8'(balance), 8'd0);
        step();
        chk("mid_ice_clear", prod(), 8'(P_NONE));

        // Leave a nonzero balance so the reset clear is observable.
        txn("choc_change", 2'b00, 6'd40, P_CHOC, 6'd30);

        // Reset asserted while evaluating a cold drink.
        select = 2'b10;
        money  = 6'd50;
        step();
        chk("rst_eval_prod", prod(), 8'(P_NONE));
        reset = 1'b1;
        step();
        chk("rst_mid_prod", prod(), 8'(P_NONE));
        chk("rst_mid_bal", 8'(balance), 8'd0);
        step();
        chk("rst_mid_prod2", prod(), 8'(P_NONE));
        reset = 1'b0;

        // History was cleared, so the held input dispenses exactly once.
        txn("post_rst_cold", 2'b10, 6'd50, P_COLD, 6'd0);
        idle_quiet("post_rst_hold", 4, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Product outputs are mutually exclusive.
    always @(negedge clk) begin
        if (!reset && ($countones({Chocolate, icecream, cold_drink}) > 1)) begin
            errors++;
            $display("FAIL onehot got %b expected at most one set", {Chocolate, icecream, cold_drink});
        end
    end

endmodule
